// File: rtl/traffic_pkg.sv
// Shared phase encodings and lamp codes for the junction controller.
// The WALK_CLR phase exists only when TRAFFIC_WALK_FLASH_EN is defined.
package traffic_pkg;

  localparam logic [2:0] MAIN_G = 3'd0;
  localparam logic [2:0] MAIN_Y = 3'd1;
  localparam logic [2:0] WALK   = 3'd2;
  localparam logic [2:0] SIDE_G = 3'd3;
  localparam logic [2:0] SIDE_Y = 3'd4;
`ifdef TRAFFIC_WALK_FLASH_EN
  localparam logic [2:0] WALK_CLR = 3'd5;
`endif

  // Lamp codes, {R,Y,G}
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [2:0] {
    StMainG   = MAIN_G,
    StMainY   = MAIN_Y,
    StWalk    = WALK,
    StSideG   = SIDE_G,
`ifdef TRAFFIC_WALK_FLASH_EN
    StWalkClr = WALK_CLR,
`endif
    StSideY   = SIDE_Y
  } phase_e;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter advanced by a tick enable; done fires on the tick
// that finds the count at zero.
module phase_timer #(
  parameter int unsigned       CNT_W   = 4,
  parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = tick_i && (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-road junction phase sequencer with pedestrian WALK insertion.
// Define TRAFFIC_WALK_FLASH_EN to add a flashing WALK_CLR clearance phase.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int unsigned T_BASE  = 6,
  parameter int unsigned T_EXT   = 12,
  parameter int unsigned T_YEL   = 2,
  parameter int unsigned T_WALK  = 3,
`ifdef TRAFFIC_WALK_FLASH_EN
  parameter int unsigned T_FLASH = 4,
`endif
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       tick_1hz,
  input  logic       walk_status,
  input  logic       sensor_in,
  output logic       walk_reg_clear,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_lamp,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] LdBase  = CNT_W'(T_BASE - 1);
  localparam logic [CNT_W-1:0] LdExt   = CNT_W'(T_EXT - 1);
  localparam logic [CNT_W-1:0] LdYel   = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] LdWalk  = CNT_W'(T_WALK - 1);
`ifdef TRAFFIC_WALK_FLASH_EN
  localparam logic [CNT_W-1:0] LdFlash = CNT_W'(T_FLASH - 1);
`endif

  phase_e           state_q, state_d;
  logic             clear_q, clear_d;
  logic             done;
  logic [CNT_W-1:0] load_val;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LdBase)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (sys_reset),
    .tick_i     (tick_1hz),
    .load_i     (done),
    .load_val_i (load_val),
    .done_o     (done)
  );

  always_comb begin
    state_d = state_q;
    if (done) begin
      unique case (state_q)
        StMainG:   state_d = StMainY;
        StMainY:   state_d = walk_status ? StWalk : StSideG;
`ifdef TRAFFIC_WALK_FLASH_EN
        StWalk:    state_d = StWalkClr;
        StWalkClr: state_d = StSideG;
`else
        StWalk:    state_d = StSideG;
`endif
        StSideG:   state_d = StSideY;
        StSideY:   state_d = StMainG;
        default:   state_d = StMainG;
      endcase
    end
  end

  // Entry duration; the side sensor only matters on the SIDE_G entry edge.
  always_comb begin
    load_val = LdBase;
    unique case (state_d)
      StMainG:   load_val = LdBase;
      StMainY:   load_val = LdYel;
      StWalk:    load_val = LdWalk;
      StSideG:   load_val = sensor_in ? LdExt : LdBase;
      StSideY:   load_val = LdYel;
`ifdef TRAFFIC_WALK_FLASH_EN
      StWalkClr: load_val = LdFlash;
`endif
      default:   load_val = LdBase;
    endcase
  end

  assign clear_d = (state_d == StWalk) && (state_q != StWalk);

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q <= StMainG;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_q <= clear_d;
    end
  end

`ifdef TRAFFIC_WALK_FLASH_EN
  logic flash_q;

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      flash_q <= 1'b0;
    end else if ((state_d == StWalkClr) && (state_q != StWalkClr)) begin
      flash_q <= 1'b0;
    end else if ((state_q == StWalkClr) && tick_1hz) begin
      flash_q <= ~flash_q;
    end
  end
`endif

  always_comb begin
    main_light = RED;
    side_light = RED;
    walk_lamp  = 1'b0;
    unique case (state_q)
      StMainG:   main_light = GRN;
      StMainY:   main_light = YEL;
      StWalk:    walk_lamp  = 1'b1;
      StSideG:   side_light = GRN;
      StSideY:   side_light = YEL;
`ifdef TRAFFIC_WALK_FLASH_EN
      StWalkClr: walk_lamp  = flash_q;
`endif
      default:   ;
    endcase
  end

  assign walk_reg_clear = clear_q;
  assign phase          = state_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with an attached walk-request register model.
// Define TRAFFIC_WALK_FLASH_EN to also cover the WALK_CLR flashing phase.
module tb_traffic_phase_controller;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       sys_reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       sensor_in = 1'b0;
  logic       walk_req = 1'b0;
  logic       walk_q;
  logic       walk_reg_clear;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_lamp;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;
  int div     = 1;
  int ccnt    = 0;

  always #5 clk = ~clk;

  // Walk request register: synchronous clear has priority over a new request.
  always @(posedge clk or posedge sys_reset) begin
    if (sys_reset)           walk_q <= 1'b0;
    else if (walk_reg_clear) walk_q <= 1'b0;
    else if (walk_req)       walk_q <= 1'b1;
  end

  traffic_phase_controller dut (
    .clk            (clk),
    .sys_reset      (sys_reset),
    .tick_1hz       (tick_1hz),
    .walk_status    (walk_q),
    .sensor_in      (sensor_in),
    .walk_reg_clear (walk_reg_clear),
    .main_light     (main_light),
    .side_light     (side_light),
    .walk_lamp      (walk_lamp),
    .phase          (phase)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk cycle; tick_1hz fires on the last cycle of every div-cycle group.
  task automatic step();
    tick_1hz = ((ccnt % div) == (div - 1));
    ccnt++;
    @(posedge clk);
    #2;
  endtask

  task automatic run(input string tag, input logic [2:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, {5'b0, phase}, {5'b0, p});
      step();
    end
  endtask

  task automatic walk_phase(input string tag);
    run(tag, WALK, 3);
`ifdef TRAFFIC_WALK_FLASH_EN
    for (int i = 0; i < 4; i++) begin
      chk("flash_phase", {5'b0, phase}, {5'b0, WALK_CLR});
      chk("flash_lamp", {7'b0, walk_lamp}, (i % 2 == 1) ? 8'd1 : 8'd0);
      step();
    end
`endif
    chk("post_walk_phase", {5'b0, phase}, {5'b0, SIDE_G});
    chk("post_walk_lamp", {7'b0, walk_lamp}, 8'd0);
  endtask

  always @(negedge clk) begin
    if (!sys_reset) begin
      chk("onehot_main", {7'b0, $onehot(main_light)}, 8'd1);
      chk("onehot_side", {7'b0, $onehot(side_light)}, 8'd1);
      chk("one_road", {7'b0, (main_light != RED) && (side_light != RED)}, 8'd0);
      chk("walk_red", {7'b0, walk_lamp && !((main_light == RED) && (side_light == RED))}, 8'd0);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_phase", {5'b0, phase}, {5'b0, MAIN_G});
    chk("rst_main", {5'b0, main_light}, 8'b001);
    chk("rst_side", {5'b0, side_light}, 8'b100);
    chk("rst_lamp", {7'b0, walk_lamp}, 8'd0);
    chk("rst_clear", {7'b0, walk_reg_clear}, 8'd0);
    sys_reset = 1'b0;

    // Basic cycle, no requests; mid-SIDE_G sensor pulse must not extend the phase.
    run("s1_main_g", MAIN_G, 6);
    chk("s1_main_y_light", {5'b0, main_light}, {5'b0, YEL});
    run("s1_main_y", MAIN_Y, 2);
    chk("s1_side_g_light", {5'b0, side_light}, {5'b0, GRN});
    run("s1_side_g", SIDE_G, 2);
    sensor_in = 1'b1;
    run("s1_side_g_mid", SIDE_G, 4);
    sensor_in = 1'b0;
    chk("s1_side_y_light", {5'b0, side_light}, {5'b0, YEL});
    run("s1_side_y", SIDE_Y, 2);

    // Sensor present on the SIDE_G entry edge only: 12-tick side green.
    run("s3_main_g", MAIN_G, 6);
    run("s3_main_y", MAIN_Y, 1);
    sensor_in = 1'b1;
    run("s3_main_y", MAIN_Y, 1);
    run("s3_side_g", SIDE_G, 1);
    sensor_in = 1'b0;
    run("s3_side_g", SIDE_G, 11);
    run("s3_side_y", SIDE_Y, 2);

    // Walk request pulse during MAIN_G stays pending until MAIN_Y exits.
    walk_req = 1'b1;
    run("s2_main_g", MAIN_G, 1);
    walk_req = 1'b0;
    chk("s2_pending", {7'b0, walk_q}, 8'd1);
    run("s2_main_g", MAIN_G, 5);
    run("s2_main_y", MAIN_Y, 2);
    chk("s2_clear_first", {7'b0, walk_reg_clear}, 8'd1);
    chk("s2_lamp_first", {7'b0, walk_lamp}, 8'd1);
    chk("s2_main_red", {5'b0, main_light}, {5'b0, RED});
    chk("s2_side_red", {5'b0, side_light}, {5'b0, RED});
    run("s2_walk", WALK, 1);
    chk("s2_clear_second", {7'b0, walk_reg_clear}, 8'd0);
    chk("s2_status_cleared", {7'b0, walk_q}, 8'd0);
    chk("s2_lamp_second", {7'b0, walk_lamp}, 8'd1);
    walk_req = 1'b1;
    run("s2_walk", WALK, 1);
    walk_req = 1'b0;
    chk("s2_late_pending", {7'b0, walk_q}, 8'd1);
    chk("s2_lamp_third", {7'b0, walk_lamp}, 8'd1);
    run("s2_walk", WALK, 1);
`ifdef TRAFFIC_WALK_FLASH_EN
    for (int i = 0; i < 4; i++) begin
      chk("s2_flash_phase", {5'b0, phase}, {5'b0, WALK_CLR});
      chk("s2_flash_lamp", {7'b0, walk_lamp}, (i % 2 == 1) ? 8'd1 : 8'd0);
      step();
    end
`endif
    chk("s2_side_g_lamp", {7'b0, walk_lamp}, 8'd0);
    run("s2_side_g", SIDE_G, 6);
    run("s2_side_y", SIDE_Y, 2);
    run("s2b_main_g", MAIN_G, 6);
    run("s2b_main_y", MAIN_Y, 2);
    chk("s2b_clear", {7'b0, walk_reg_clear}, 8'd1);
    walk_phase("s2b_walk");
    run("s2b_side_g", SIDE_G, 6);
    chk("s2b_no_pending", {7'b0, walk_q}, 8'd0);
    run("s2b_side_y", SIDE_Y, 2);

    // Tick every 4 clks: durations stretch by 4x, timer holds between ticks.
    div  = 4;
    ccnt = 0;
    run("s4_main_g", MAIN_G, 24);
    run("s4_main_y", MAIN_Y, 8);
    div  = 1;
    ccnt = 0;

    // Asynchronous reset mid-SIDE_Y takes effect before the next edge.
    run("s5_side_g", SIDE_G, 6);
    run("s5_side_y", SIDE_Y, 1);
    #1 sys_reset = 1'b1;
    #1;
    chk("s5_rst_phase", {5'b0, phase}, {5'b0, MAIN_G});
    chk("s5_rst_main", {5'b0, main_light}, 8'b001);
    chk("s5_rst_side", {5'b0, side_light}, 8'b100);
    chk("s5_rst_lamp", {7'b0, walk_lamp}, 8'd0);
    chk("s5_rst_clear", {7'b0, walk_reg_clear}, 8'd0);
    @(posedge clk);
    #2;
    chk("s5_rst_hold", {5'b0, phase}, {5'b0, MAIN_G});
    sys_reset = 1'b0;
    run("s5_main_g", MAIN_G, 6);
    chk("s5_main_y", {5'b0, phase}, {5'b0, MAIN_Y});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Top-level phase sequencer for the two-road junction.
- Cycles main/side signal heads through green/yellow/red.
- Inserts a pedestrian WALK phase when the walk request register reports a pending request.
- Clears that register through its reset input when the request is served.
- Timing is counted in `tick_1hz` enables from the board prescaler.

Parameters:
- T_BASE, 6: main-green and default side-green duration, in ticks.
- T_EXT, 12: extended side-green duration, in ticks, used when the side sensor is active.
- T_YEL, 2: yellow duration for either road, in ticks.
- T_WALK, 3: steady walk-lamp duration, in ticks.
- T_FLASH, 4: flashing clearance duration, in ticks. Used only with WALK_FLASH_EN.
- CNT_W, 4: phase timer width. Every duration must satisfy 1 ≤ T < 2^CNT_W.

Ports:
- clk  in  1  system clock.
- sys_reset  in  1  asynchronous, active-high reset.
- tick_1hz  in  1  one-clk-wide timing enable.
- walk_status  in  1  pending pedestrian request, from the walk register.
- sensor_in  in  1  side-road vehicle present.
- walk_reg_clear  out  1  drives the walk register's reset input.
- main_light  out  3  {R,Y,G}, one-hot.
- side_light  out  3  {R,Y,G}, one-hot.
- walk_lamp  out  1  pedestrian walk lamp.
- phase  out  3  current state encoding, for debug/LEDs.

Behaviour:
- One clock (`clk`). Reset `sys_reset` is asynchronous and active-high. All state is flopped on posedge `clk` or posedge `sys_reset`.
- Reset values:
  - phase = MAIN_G.
  - main_light = 001.
  - side_light = 100.
  - walk_lamp = 0.
  - walk_reg_clear = 0.
  - timer = T_BASE-1.
- States and their outputs:
  - MAIN_G: main G, side R.
  - MAIN_Y: main Y, side R.
  - WALK: both R, walk_lamp = 1.
  - SIDE_G: main R, side G.
  - SIDE_Y: main R, side Y.
  - WALK_CLR: exists only with WALK_FLASH_EN.
- Timer behaviour:
  - On entry to a state, the timer loads (duration-1).
  - It decrements on each cycle with `tick_1hz` = 1.
  - The state is done on the clk edge where `tick_1hz` = 1 and timer = 0.
  - Each phase therefore lasts exactly "duration" ticks.
  - With no tick, nothing advances.
- Transitions, each taken on the done edge:
  - MAIN_G → MAIN_Y.
  - MAIN_Y → WALK if `walk_status` = 1 at that edge, else → SIDE_G.
  - WALK → SIDE_G.
  - SIDE_G → SIDE_Y.
  - SIDE_Y → MAIN_G.
- SIDE_G duration:
  - T_EXT if `sensor_in` = 1 on the entry edge, else T_BASE.
  - `sensor_in` is sampled only at entry and ignored afterwards.
- walk_reg_clear:
  - Registered.
  - High for exactly the first clk cycle of WALK, low otherwise.
  - Because the walk register is synchronous with reset priority, it reads 0 from the second WALK cycle onward.
  - A request arriving in the first WALK cycle is dropped. This is acceptable because walk is already lit.
  - Requests arriving later in WALK, or in any other state, stay pending for the next MAIN_Y exit.
- Simultaneous events:
  - `walk_status` rising in the same cycle as the MAIN_Y done edge is honoured, because the registered value at that edge is used.
  - `sensor_in` changes mid-phase have no effect.
- Invariant: at most one road is non-red at any time. `walk_lamp` = 1 only when both roads are red.
- Reset mid-phase: immediate return to the reset values, including clearing `walk_reg_clear`. No partial phase completes.

Optional Feature:
- Macro: TRAFFIC_WALK_FLASH_EN.
- Defined:
  - WALK done → WALK_CLR for T_FLASH ticks, with both roads red.
  - walk_lamp starts at 0 on entry and toggles on every tick.
  - WALK_CLR done → SIDE_G, with walk_lamp forced to 0.
- Undefined: the WALK_CLR state, its encoding and the toggle logic are absent, and WALK → SIDE_G directly.

Decomposition:
- Package traffic_pkg holds:
  - state encoding localparams: MAIN_G=0, MAIN_Y=1, WALK=2, SIDE_G=3, SIDE_Y=4, WALK_CLR=5;
  - light codes: RED=3'b100, YEL=3'b010, GRN=3'b001.
- One sub-module, phase_timer:
  - CNT_W-wide loadable down-counter with tick enable;
  - load strobe and value inputs;
  - done output (tick && cnt==0).

Test Plan:
- Reset, tick every clk, walk_status=0, sensor=0:
  - MAIN_G 6 cycles → MAIN_Y 2 → SIDE_G 6 → SIDE_Y 2 → MAIN_G.
  - walk_lamp and walk_reg_clear stay 0 throughout.
- walk_status held 1 from reset (walk register model attached, tick every clk):
  - WALK entered after cycle 8, walk_reg_clear = 1 for exactly 1 cycle, walk_lamp = 1 for 3 cycles.
  - walk_status = 0 from the 2nd WALK cycle, then SIDE_G.
- sensor_in=1 at SIDE_G entry, dropped after 1 cycle: SIDE_G lasts 12 ticks.
- Tick every 4 clks: MAIN_G lasts 24 clks and the timer holds between ticks.
- Assert sys_reset asynchronously mid-SIDE_Y: outputs reach reset values before the next clk edge, then a normal 6-tick MAIN_G follows.
- With TRAFFIC_WALK_FLASH_EN: after WALK, walk_lamp reads 0,1,0,1 across 4 ticks of WALK_CLR, then SIDE_G with walk_lamp = 0.
- All scenarios: one-hot and invariant assertions checked every cycle.
